// File: rtl/fb_cond_eval.sv
// rtl/fb_cond_eval.sv - NZCV condition evaluator with in-flight flag-writer tracking
// Stalls condition requests until pending flag writes retire, bypassing same-cycle write data.
module fb_cond_eval #(
   parameter int PEND_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       nf,
   input  logic       zf,
   input  logic       cf,
   input  logic       vf,
   input  logic       flags_we,
   input  logic [3:0] flags_in,
   input  logic       set_issue,
   output logic       issue_ready,
   input  logic       cond_valid,
   input  logic [3:0] cond,
   output logic       cond_ready,
   output logic       res_valid,
   output logic       res_taken,
   output logic       err
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PEND_W-1:0] pend;
   logic [PEND_W-1:0] pend_next;
   logic [3:0]        cond_held;
   logic [3:0]        cond_held_next;
   logic              res_valid_next;
   logic              res_taken_next;
   logic              err_set;
   logic              inc;
   logic              resolvable;
   logic [3:0]        eff_flags;

   function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n  = f[3];
      z  = f[2];
      cy = f[1];
      v  = f[0];
      case (c)
         4'h0:    eval_cond = z;
         4'h1:    eval_cond = !z;
         4'h2:    eval_cond = cy;
         4'h3:    eval_cond = !cy;
         4'h4:    eval_cond = n;
         4'h5:    eval_cond = !n;
         4'h6:    eval_cond = v;
         4'h7:    eval_cond = !v;
         4'h8:    eval_cond = cy & !z;
         4'h9:    eval_cond = !cy | z;
         4'hA:    eval_cond = (n == v);
         4'hB:    eval_cond = (n != v);
         4'hC:    eval_cond = !z & (n == v);
         4'hD:    eval_cond = z | (n != v);
         4'hE:    eval_cond = 1'b1;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   assign issue_ready = (pend != PEND_MAX);
   assign cond_ready  = (state == S_IDLE);
   assign inc         = set_issue & issue_ready;
   assign eff_flags   = flags_we ? flags_in : {nf, zf, cf, vf};
   // A same-cycle set_issue belongs to a younger instruction, so only registered pend matters.
   assign resolvable  = (pend == '0) | ((pend == PEND_ONE) & flags_we);

   always_comb begin
      pend_next = pend;
      err_set   = 1'b0;
      if (set_issue && !issue_ready) begin
         err_set = 1'b1;
      end
      if (flags_we && (pend == '0) && !set_issue) begin
         err_set = 1'b1;
      end
      if (inc && !flags_we) begin
         pend_next = pend + PEND_ONE;
      end else if (!inc && flags_we && (pend != '0)) begin
         pend_next = pend - PEND_ONE;
      end
   end

   always_comb begin
      state_next     = state;
      cond_held_next = cond_held;
      res_valid_next = 1'b0;
      res_taken_next = res_taken;
      case (state)
         S_IDLE: begin
            if (cond_valid) begin
               if (resolvable) begin
                  res_valid_next = 1'b1;
                  res_taken_next = eval_cond(cond, eff_flags);
               end else begin
                  cond_held_next = cond;
                  state_next     = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (resolvable) begin
               res_valid_next = 1'b1;
               res_taken_next = eval_cond(cond_held, eff_flags);
               state_next     = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pend      <= '0;
         cond_held <= 4'h0;
         res_valid <= 1'b0;
         res_taken <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_next;
         pend      <= pend_next;
         cond_held <= cond_held_next;
         res_valid <= res_valid_next;
         res_taken <= res_taken_next;
         err       <= err | err_set;
      end
   end

endmodule

// File: tb/tb_fb_cond_eval.sv
// tb/tb_fb_cond_eval.sv - directed table-driven bench for fb_cond_eval
// Condition table applied back-to-back, then hand-written hazard, saturation and reset sequences.
module tb_fb_cond_eval;

   logic       clk = 1'b0;
   logic       rst;
   logic       nf, zf, cf, vf;
   logic       flags_we;
   logic [3:0] flags_in;
   logic       set_issue;
   logic       issue_ready;
   logic       cond_valid;
   logic [3:0] cond;
   logic       cond_ready;
   logic       res_valid;
   logic       res_taken;
   logic       err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] cnd;
      logic [3:0] flags;
      logic       taken;
   } vec_t;

   vec_t vecs[22];

   fb_cond_eval #(.PEND_W(2)) dut (
      .clk(clk), .rst(rst),
      .nf(nf), .zf(zf), .cf(cf), .vf(vf),
      .flags_we(flags_we), .flags_in(flags_in),
      .set_issue(set_issue), .issue_ready(issue_ready),
      .cond_valid(cond_valid), .cond(cond), .cond_ready(cond_ready),
      .res_valid(res_valid), .res_taken(res_taken), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{4'h0, 4'b0100, 1'b1};
      vecs[1]  = '{4'h1, 4'b0100, 1'b0};
      vecs[2]  = '{4'h0, 4'b0000, 1'b0};
      vecs[3]  = '{4'h2, 4'b0010, 1'b1};
      vecs[4]  = '{4'h3, 4'b0010, 1'b0};
      vecs[5]  = '{4'h4, 4'b1000, 1'b1};
      vecs[6]  = '{4'h5, 4'b1000, 1'b0};
      vecs[7]  = '{4'h6, 4'b0001, 1'b1};
      vecs[8]  = '{4'h7, 4'b0000, 1'b1};
      vecs[9]  = '{4'h8, 4'b0010, 1'b1};
      vecs[10] = '{4'h8, 4'b0110, 1'b0};
      vecs[11] = '{4'h9, 4'b0000, 1'b1};
      vecs[12] = '{4'h9, 4'b0010, 1'b0};
      vecs[13] = '{4'hA, 4'b1001, 1'b1};
      vecs[14] = '{4'hA, 4'b1000, 1'b0};
      vecs[15] = '{4'hB, 4'b0001, 1'b1};
      vecs[16] = '{4'hC, 4'b0000, 1'b1};
      vecs[17] = '{4'hC, 4'b0100, 1'b0};
      vecs[18] = '{4'hD, 4'b1000, 1'b1};
      vecs[19] = '{4'hD, 4'b0000, 1'b0};
      vecs[20] = '{4'hF, 4'b1111, 1'b0};
      vecs[21] = '{4'hE, 4'b0000, 1'b1};

      rst = 1'b1;
      {nf, zf, cf, vf} = 4'b0100;
      flags_we = 1'b0; flags_in = 4'h0;
      set_issue = 1'b0; cond_valid = 1'b0; cond = 4'h0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_cond_ready", cond_ready, 1);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_taken", res_taken, 0);
      chk("rst_err", err, 0);

      // back-to-back condition table, pend = 0
      for (int i = 0; i < 22; i++) begin
         {nf, zf, cf, vf} = vecs[i].flags;
         cond = vecs[i].cnd;
         cond_valid = 1'b1;
         chk($sformatf("tbl%0d_ready", i), cond_ready, 1);
         tick();
         chk($sformatf("tbl%0d_valid", i), res_valid, 1);
         chk($sformatf("tbl%0d_taken", i), res_taken, vecs[i].taken);
      end
      cond_valid = 1'b0;
      tick();
      chk("hold_valid", res_valid, 0);
      chk("hold_taken", res_taken, 1);

      // blocked HI resolved via flags_in bypass
      {nf, zf, cf, vf} = 4'b0100;
      set_issue = 1'b1;
      tick();
      set_issue = 1'b0;
      cond_valid = 1'b1; cond = 4'h8;
      tick();
      cond_valid = 1'b0;
      chk("hi_stall_ready", cond_ready, 0);
      chk("hi_stall_valid", res_valid, 0);
      tick();
      tick();
      chk("hi_still_ready", cond_ready, 0);
      chk("hi_still_valid", res_valid, 0);
      tick();
      flags_we = 1'b1; flags_in = 4'b0010;
      tick();
      flags_we = 1'b0;
      chk("hi_valid", res_valid, 1);
      chk("hi_taken", res_taken, 1);
      chk("hi_ready_back", cond_ready, 1);
      chk("hi_err", err, 0);
      tick();
      chk("hi_pulse_end", res_valid, 0);

      // younger set_issue does not block; pend=1 afterwards blocks the next request
      {nf, zf, cf, vf} = 4'b1000;
      set_issue = 1'b1; cond_valid = 1'b1; cond = 4'hB;
      tick();
      set_issue = 1'b0;
      chk("lt_valid", res_valid, 1);
      chk("lt_taken", res_taken, 1);
      cond = 4'h7;
      tick();
      cond_valid = 1'b0;
      chk("p1_block_ready", cond_ready, 0);
      chk("p1_block_valid", res_valid, 0);
      flags_we = 1'b1; flags_in = 4'b0001;
      tick();
      flags_we = 1'b0;
      chk("p1_vc_valid", res_valid, 1);
      chk("p1_vc_taken", res_taken, 0);
      chk("p1_err", err, 0);

      // AL result leaves res_taken=1 before the reset test
      cond_valid = 1'b1; cond = 4'hE;
      tick();
      cond_valid = 1'b0;
      chk("al_taken", res_taken, 1);

      // reset during WAIT with pend=2
      set_issue = 1'b1;
      tick();
      tick();
      set_issue = 1'b0;
      cond_valid = 1'b1; cond = 4'hE;
      tick();
      cond_valid = 1'b0;
      chk("w2_ready", cond_ready, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("arst_ready", cond_ready, 1);
      chk("arst_valid", res_valid, 0);
      chk("arst_taken", res_taken, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("arst_hold%0d_valid", i), res_valid, 0);
      end
      rst = 1'b0;
      tick();
      chk("post_rst_valid", res_valid, 0);
      chk("post_rst_issue_ready", issue_ready, 1);
      chk("post_rst_err", err, 0);
      cond_valid = 1'b1; cond = 4'hE;
      tick();
      cond_valid = 1'b0;
      chk("post_rst_res", res_valid, 1);

      // counter saturation
      set_issue = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("sat%0d_issue_ready", i), issue_ready, (i < 2) ? 1 : 0);
      end
      chk("sat_err_before", err, 0);
      tick();
      set_issue = 1'b0;
      chk("sat_err", err, 1);
      chk("sat_issue_ready", issue_ready, 0);
      flags_we = 1'b1;
      tick();
      chk("sat_dec_issue_ready", issue_ready, 1);
      tick();
      flags_we = 1'b0;
      cond_valid = 1'b1; cond = 4'hE;
      tick();
      cond_valid = 1'b0;
      chk("sat_p1_block", cond_ready, 0);
      chk("sat_p1_valid", res_valid, 0);
      flags_we = 1'b1; flags_in = 4'h0;
      tick();
      flags_we = 1'b0;
      chk("sat_p1_res", res_valid, 1);
      chk("sat_err_sticky", err, 1);

      // underflow
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("uf_err_clear", err, 0);
      flags_we = 1'b1; flags_in = 4'h0;
      tick();
      flags_we = 1'b0;
      chk("uf_err", err, 1);
      chk("uf_issue_ready", issue_ready, 1);
      cond_valid = 1'b1; cond = 4'hE;
      tick();
      cond_valid = 1'b0;
      chk("uf_resolvable", res_valid, 1);
      tick();
      tick();
      chk("uf_err_persist", err, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("uf_err_rst", err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_cond_eval.md
# fb_cond_eval

Condition-code evaluator that consumes the NZCV flags held by the pipeline flag register and resolves conditional branch/execute requests against them. It sits beside the flag register: it snoops the same write strobe and write data, tracks how many flag-setting instructions are in flight, stalls requests until the flags they depend on are final, and returns a registered taken/not-taken result.

## Interface
Parameters:
- PEND_W, 2, width of the in-flight flag-writer counter; maximum pending count is 2^PEND_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- nf, zf, cf, vf  input  1 each  current architectural flags from the flag register.
- flags_we  input  1  flag register write strobe; one flag-writer retires.
- flags_in  input  4  flag write data {N,Z,C,V}, valid when flags_we=1.
- set_issue  input  1  a flag-setting instruction has issued; pending count increments.
- issue_ready  output  1  1 when pending < 2^PEND_W-1.
- cond_valid  input  1  condition request present.
- cond  input  4  condition code.
- cond_ready  output  1  request accepted when cond_valid & cond_ready.
- res_valid  output  1  one-cycle pulse: result available.
- res_taken  output  1  condition result, valid with res_valid.
- err  output  1  sticky protocol error.

## Operation
- Condition codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Pending counter `pend` (PEND_W bits): +1 on accepted set_issue, -1 on flags_we, unchanged when both occur in the same cycle.
- flags_we with pend=0 (and no same-cycle set_issue): counter stays 0, err set. set_issue while issue_ready=0: ignored, err set. err clears only on rst.
- Effective flags: flags_in when flags_we=1, else {nf,zf,cf,vf}.
- Resolvable (evaluated on registered pend): pend=0, or pend=1 & flags_we. A set_issue in the same cycle as a request is younger and never blocks it.
- FSM, two states:
  - IDLE: cond_ready=1. On cond_valid: if resolvable, evaluate cond with effective flags, register result, stay IDLE; else latch cond, go WAIT.
  - WAIT: cond_ready=0. Each cycle test resolvability; when resolvable, evaluate latched cond with effective flags, register result, go IDLE.
- res_valid is a single-cycle pulse, with no output back-pressure. res_taken holds its last value when res_valid=0.

## Timing
- Reset values: state IDLE, pend 0, res_valid 0, res_taken 0, err 0; cond_ready=1 and issue_ready=1 immediately after reset.
- Resolvable request accepted in cycle T -> res_valid=1 in T+1.
- Blocked request: the final flags_we in cycle W -> res_valid=1 in W+1, computed from flags_in of W. cond_ready returns to 1 in W+1.
- Throughput: one result per cycle with no hazards; back-to-back requests are accepted each cycle in IDLE.
- issue_ready is combinational from registered pend only.
- rst asserted mid-WAIT: the latched request is discarded and no res_valid is produced.
- Counter never wraps: increments are blocked at max, and decrements are blocked at 0.

## Test plan
- Reset, flags N=0 Z=1 C=0 V=0, pend 0, request cond=0 (EQ) at T -> res_valid in T+1, res_taken=1. Request cond=1 at T+1 -> res_taken=0 at T+2.
- set_issue at cycle 0, then request cond=8 (HI) at cycle 1 -> cond_ready=0 from cycle 2. flags_we with flags_in=4'b0010 at cycle 5 -> res_valid at 6, res_taken=1. The register still shows old flags at 5, which proves the bypass.
- set_issue 3 times (PEND_W=2) -> issue_ready=0. A 4th set_issue -> ignored, err=1, pend stays 3.
- flags_we with pend=0 -> err=1, pend stays 0. err persists until rst.
- Same-cycle set_issue + cond_valid with pend=0, N=1 V=0, cond=B (LT) -> accepted immediately, res_taken=1 next cycle, pend=1 afterwards.
- WAIT with pend=2, assert rst -> res_valid never pulses. All outputs at reset values; cond_ready=1 and pend=0 after release.
